// File: rtl/sys_cmd_master_if.sv
// Command / byte-stream bundle between the host-side command master,
// its requester, and the UART transmitter and receiver.
interface sys_cmd_master_if;
    // Command request from the host/test controller
    logic        CMD_VLD;
    logic        CMD_RDY;
    logic [1:0]  CMD_TYPE;
    logic [3:0]  CMD_ADDR;
    logic [7:0]  CMD_DATA;
    logic [7:0]  CMD_OPB;
    logic [3:0]  CMD_FUN;
    // Byte stream towards the UART transmitter
    logic [7:0]  TX_DATA;
    logic        TX_VLD;
    logic        TX_RDY;
    // Byte pulses from the UART receiver
    logic [7:0]  RX_DATA;
    logic        RX_VLD;
    // Completion report
    logic [15:0] RSP_DATA;
    logic        RSP_VLD;
    logic        RSP_TIMEOUT;
    logic        BUSY;

    modport master (
        input  CMD_VLD, CMD_TYPE, CMD_ADDR, CMD_DATA, CMD_OPB, CMD_FUN,
        input  TX_RDY, RX_DATA, RX_VLD,
        output CMD_RDY, TX_DATA, TX_VLD, RSP_DATA, RSP_VLD, RSP_TIMEOUT, BUSY
    );

    modport slave (
        output CMD_VLD, CMD_TYPE, CMD_ADDR, CMD_DATA, CMD_OPB, CMD_FUN,
        output TX_RDY, RX_DATA, RX_VLD,
        input  CMD_RDY, TX_DATA, TX_VLD, RSP_DATA, RSP_VLD, RSP_TIMEOUT, BUSY
    );
endinterface

// File: rtl/sys_cmd_master.sv
// Host-side UART command initiator: frames one command into bytes for the
// UART transmitter, gathers 0/1/2 response bytes from the receiver and
// reports a 16-bit result or a per-byte timeout. All outputs are registered.
module sys_cmd_master #(
    parameter int TIMEOUT_CYC = 65535,
    parameter int CNT_W       = 16
) (
    input  logic              CLK,
    input  logic              RST,
    sys_cmd_master_if.master  bus
);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP, DONE} state_t;

    localparam logic [1:0]       T_WR     = 2'd0;
    localparam logic [1:0]       T_RD     = 2'd1;
    localparam logic [1:0]       T_ALU    = 2'd2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t           state_q, state_d;
    logic [7:0]       frame_q [4];
    logic [7:0]       frame_d [4];
    logic [1:0]       last_idx_q, last_idx_d;
    logic [1:0]       type_q, type_d;
    logic [1:0]       idx_q, idx_d;
    logic             rx_idx_q, rx_idx_d;
    logic [7:0]       rx_b0_q, rx_b0_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_vld_q, tx_vld_d;
    logic             cmd_rdy_q, cmd_rdy_d;
    logic [15:0]      rsp_data_q, rsp_data_d;
    logic             rsp_vld_q, rsp_vld_d;
    logic             rsp_to_q, rsp_to_d;
    logic             busy_q, busy_d;

    logic accept;
    logic tx_fire;
    logic rx_last;

    assign accept  = (state_q == IDLE) && cmd_rdy_q && bus.CMD_VLD;
    assign tx_fire = tx_vld_q && bus.TX_RDY;
    // A read needs one response byte; ALU commands need two (LSB then MSB).
    assign rx_last = (type_q == T_RD) || rx_idx_q;

    // Next-state, frame/response bookkeeping and next values of every registered output
    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        last_idx_d = last_idx_q;
        type_d     = type_q;
        idx_d      = idx_q;
        rx_idx_d   = rx_idx_q;
        rx_b0_d    = rx_b0_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_to_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    type_d  = bus.CMD_TYPE;
                    idx_d   = 2'd0;
                    state_d = SEND;
                    case (bus.CMD_TYPE)
                        T_WR: begin
                            frame_d[0] = 8'hAA;
                            frame_d[1] = {4'h0, bus.CMD_ADDR};
                            frame_d[2] = bus.CMD_DATA;
                            last_idx_d = 2'd2;
                        end
                        T_RD: begin
                            frame_d[0] = 8'hBB;
                            frame_d[1] = {4'h0, bus.CMD_ADDR};
                            last_idx_d = 2'd1;
                        end
                        T_ALU: begin
                            frame_d[0] = 8'hCC;
                            frame_d[1] = bus.CMD_DATA;
                            frame_d[2] = bus.CMD_OPB;
                            frame_d[3] = {4'h0, bus.CMD_FUN};
                            last_idx_d = 2'd3;
                        end
                        default: begin
                            frame_d[0] = 8'hDD;
                            frame_d[1] = {4'h0, bus.CMD_FUN};
                            last_idx_d = 2'd1;
                        end
                    endcase
                end
            end
            SEND: begin
                if (tx_fire) begin
                    if (idx_q == last_idx_q) begin
                        if (type_q == T_WR) begin
                            state_d    = DONE;
                            rsp_data_d = 16'h0000;
                        end else begin
                            state_d  = WAIT_RSP;
                            cnt_d    = '0;
                            rx_idx_d = 1'b0;
                        end
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            WAIT_RSP: begin
                // A byte arriving on the terminal count still wins over the timeout.
                if (bus.RX_VLD) begin
                    cnt_d    = '0;
                    rx_idx_d = 1'b1;
                    if (!rx_idx_q) begin
                        rx_b0_d = bus.RX_DATA;
                    end
                    if (rx_last) begin
                        state_d    = DONE;
                        rsp_data_d = (type_q == T_RD) ? {8'h00, bus.RX_DATA}
                                                      : {bus.RX_DATA, rx_b0_q};
                    end
                end else if (cnt_q == CNT_LAST) begin
                    rsp_to_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs follow the state being entered so they line up with it.
        // The timeout pulse cycle keeps CMD_RDY low; acceptance opens one cycle later.
        tx_vld_d  = (state_d == SEND);
        tx_data_d = (state_d == SEND) ? frame_d[idx_d] : tx_data_q;
        cmd_rdy_d = (state_d == IDLE) && !rsp_to_d;
        busy_d    = (state_d != IDLE);
        rsp_vld_d = (state_d == DONE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= IDLE;
            frame_q    <= '{default: 8'h00};
            last_idx_q <= 2'd0;
            type_q     <= 2'd0;
            idx_q      <= 2'd0;
            rx_idx_q   <= 1'b0;
            rx_b0_q    <= 8'h00;
            cnt_q      <= '0;
            tx_data_q  <= 8'h00;
            tx_vld_q   <= 1'b0;
            cmd_rdy_q  <= 1'b1;
            rsp_data_q <= 16'h0000;
            rsp_vld_q  <= 1'b0;
            rsp_to_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            last_idx_q <= last_idx_d;
            type_q     <= type_d;
            idx_q      <= idx_d;
            rx_idx_q   <= rx_idx_d;
            rx_b0_q    <= rx_b0_d;
            cnt_q      <= cnt_d;
            tx_data_q  <= tx_data_d;
            tx_vld_q   <= tx_vld_d;
            cmd_rdy_q  <= cmd_rdy_d;
            rsp_data_q <= rsp_data_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_to_q   <= rsp_to_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.CMD_RDY     = cmd_rdy_q;
    assign bus.TX_DATA     = tx_data_q;
    assign bus.TX_VLD      = tx_vld_q;
    assign bus.RSP_DATA    = rsp_data_q;
    assign bus.RSP_VLD     = rsp_vld_q;
    assign bus.RSP_TIMEOUT = rsp_to_q;
    assign bus.BUSY        = busy_q;

endmodule

// File: tb/tb_sys_cmd_master.sv
// Scoreboard bench for sys_cmd_master: expected TX bytes and responses are
// queued when a command is issued and popped by a monitor on the falling edge.
module tb_sys_cmd_master;

    localparam int TO = 16;

    typedef struct {
        logic [1:0]  kind;   // 1 = RSP_VLD, 2 = RSP_TIMEOUT
        logic [15:0] data;
    } rsp_t;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    sys_cmd_master_if sig();

    sys_cmd_master #(.TIMEOUT_CYC(TO), .CNT_W(16)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (sig)
    );

    int         n_vec   = 0;
    int         n_err   = 0;
    int         rsp_cnt = 0;
    logic [7:0] tx_q [$];
    rsp_t       rsp_q [$];
    rsp_t       mon_e;
    logic       pv   = 1'b0;
    logic       pr   = 1'b0;
    logic       prst = 1'b0;
    logic [7:0] pd   = 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: TX byte scoreboard, stall stability, response scoreboard
    always @(negedge CLK) begin
        if (RST && prst && pv && !pr) begin
            chk("tx_hold_vld", {31'd0, sig.TX_VLD}, 32'd1);
            chk("tx_hold_data", {24'd0, sig.TX_DATA}, {24'd0, pd});
        end
        if (RST && sig.TX_VLD && sig.TX_RDY) begin
            if (tx_q.size() == 0) chk("tx_unexpected", {24'd0, sig.TX_DATA}, 32'hFFFF_FFFF);
            else chk("tx_byte", {24'd0, sig.TX_DATA}, {24'd0, tx_q.pop_front()});
        end
        if (sig.RSP_VLD || sig.RSP_TIMEOUT) begin
            rsp_cnt++;
            if (rsp_q.size() == 0) begin
                chk("rsp_unexpected", {30'd0, sig.RSP_TIMEOUT, sig.RSP_VLD}, 32'd0);
            end else begin
                mon_e = rsp_q.pop_front();
                chk("rsp_kind", {30'd0, sig.RSP_TIMEOUT, sig.RSP_VLD}, {30'd0, mon_e.kind});
                chk("rsp_data", {16'd0, sig.RSP_DATA}, {16'd0, mon_e.data});
            end
        end
        pv   <= sig.TX_VLD;
        pr   <= sig.TX_RDY;
        pd   <= sig.TX_DATA;
        prst <= RST;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_cmd_rdy"}, {31'd0, sig.CMD_RDY}, 32'd1);
        chk({tag, "_tx_vld"}, {31'd0, sig.TX_VLD}, 32'd0);
        chk({tag, "_tx_data"}, {24'd0, sig.TX_DATA}, 32'd0);
        chk({tag, "_rsp_data"}, {16'd0, sig.RSP_DATA}, 32'd0);
        chk({tag, "_rsp_vld"}, {31'd0, sig.RSP_VLD}, 32'd0);
        chk({tag, "_rsp_to"}, {31'd0, sig.RSP_TIMEOUT}, 32'd0);
        chk({tag, "_busy"}, {31'd0, sig.BUSY}, 32'd0);
    endtask

    // Issue one command; returns in the first cycle after the accept edge
    task automatic issue(input logic [1:0] t, input logic [3:0] a, input logic [7:0] d,
                         input logic [7:0] b, input logic [3:0] f);
        sig.CMD_TYPE = t;
        sig.CMD_ADDR = a;
        sig.CMD_DATA = d;
        sig.CMD_OPB  = b;
        sig.CMD_FUN  = f;
        sig.CMD_VLD  = 1'b1;
        for (int i = 0; i < 100 && !sig.CMD_RDY; i++) tick();
        chk("cmd_rdy_wait", {31'd0, sig.CMD_RDY}, 32'd1);
        tick();
        sig.CMD_VLD  = 1'b0;
        sig.CMD_TYPE = ~t;
        sig.CMD_ADDR = ~a;
        sig.CMD_DATA = ~d;
        sig.CMD_OPB  = ~b;
        sig.CMD_FUN  = ~f;
        chk("busy_after_accept", {31'd0, sig.BUSY}, 32'd1);
        chk("rdy_after_accept", {31'd0, sig.CMD_RDY}, 32'd0);
    endtask

    task automatic rx_byte(input logic [7:0] b);
        sig.RX_VLD  = 1'b1;
        sig.RX_DATA = b;
        tick();
        sig.RX_VLD  = 1'b0;
        sig.RX_DATA = 8'h00;
    endtask

    task automatic wait_tx_done();
        for (int i = 0; i < 200 && tx_q.size() != 0; i++) tick();
        chk("tx_drain", tx_q.size(), 32'd0);
    endtask

    task automatic wait_rsp(input int target);
        for (int i = 0; i < 300 && rsp_cnt < target; i++) tick();
        chk("rsp_wait", rsp_cnt, target);
    endtask

    function automatic rsp_t mk(input logic [1:0] k, input logic [15:0] d);
        rsp_t r;
        r.kind = k;
        r.data = d;
        return r;
    endfunction

    initial begin
        int k;
        sig.CMD_VLD = 1'b0; sig.CMD_TYPE = 2'd0; sig.CMD_ADDR = 4'd0;
        sig.CMD_DATA = 8'd0; sig.CMD_OPB = 8'd0; sig.CMD_FUN = 4'd0;
        sig.TX_RDY = 1'b1; sig.RX_DATA = 8'd0; sig.RX_VLD = 1'b0;
        tick();
        tick();
        check_reset("rst");
        RST = 1'b1;
        tick();

        // 1: write, TX_RDY held high -> three back-to-back bytes, then RSP_VLD
        tx_q.push_back(8'hAA); tx_q.push_back(8'h03); tx_q.push_back(8'h5A);
        rsp_q.push_back(mk(2'd1, 16'h0000));
        issue(2'd0, 4'd3, 8'h5A, 8'h00, 4'd0);
        chk("t1_vld_b0", {31'd0, sig.TX_VLD}, 32'd1);
        tick();
        chk("t1_vld_b1", {31'd0, sig.TX_VLD}, 32'd1);
        tick();
        chk("t1_vld_b2", {31'd0, sig.TX_VLD}, 32'd1);
        tick();
        chk("t1_vld_end", {31'd0, sig.TX_VLD}, 32'd0);
        chk("t1_rsp_now", {31'd0, sig.RSP_VLD}, 32'd1);
        tick();
        chk("t1_rdy_back", {31'd0, sig.CMD_RDY}, 32'd1);
        wait_rsp(1);

        // 2: read with stray bytes during SEND that must be dropped
        tx_q.push_back(8'hBB); tx_q.push_back(8'h02);
        rsp_q.push_back(mk(2'd1, 16'h0081));
        issue(2'd1, 4'd2, 8'h00, 8'h00, 4'd0);
        rx_byte(8'hEE);
        rx_byte(8'hEF);
        wait_tx_done();
        rx_byte(8'h81);
        wait_rsp(2);

        // 3: ALU with operands, TX_RDY toggling
        tx_q.push_back(8'hCC); tx_q.push_back(8'h12);
        tx_q.push_back(8'h34); tx_q.push_back(8'h01);
        rsp_q.push_back(mk(2'd1, 16'h0046));
        sig.TX_RDY = 1'b0;
        issue(2'd2, 4'd0, 8'h12, 8'h34, 4'd1);
        for (int i = 0; i < 50 && tx_q.size() != 0; i++) begin
            sig.TX_RDY = ~sig.TX_RDY;
            tick();
        end
        sig.TX_RDY = 1'b1;
        chk("t3_drain", tx_q.size(), 32'd0);
        rx_byte(8'h46);
        rx_byte(8'h00);
        wait_rsp(3);

        // 4: ALU no-op with only one response byte -> timeout after TO cycles
        tx_q.push_back(8'hDD); tx_q.push_back(8'h02);
        rsp_q.push_back(mk(2'd2, 16'h0046));
        issue(2'd3, 4'd0, 8'h00, 8'h00, 4'd2);
        wait_tx_done();
        rx_byte(8'h77);
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (sig.RSP_TIMEOUT) begin
                k = i;
                break;
            end
        end
        chk("t4_to_delay", k, TO);
        tick();
        chk("t4_rdy_next", {31'd0, sig.CMD_RDY}, 32'd1);
        chk("t4_busy_next", {31'd0, sig.BUSY}, 32'd0);
        wait_rsp(4);

        // 5: reset in the middle of a frame, then a fresh read
        tx_q.push_back(8'hAA);
        issue(2'd0, 4'd7, 8'h99, 8'h00, 4'd0);
        tick();
        RST = 1'b0;
        sig.TX_RDY = 1'b0;
        tick();
        check_reset("t5");
        RST = 1'b1;
        sig.TX_RDY = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("t5_no_pulse", rsp_cnt, 32'd4);
        tx_q.push_back(8'hBB); tx_q.push_back(8'h05);
        rsp_q.push_back(mk(2'd1, 16'h003C));
        issue(2'd1, 4'd5, 8'h00, 8'h00, 4'd0);
        wait_tx_done();
        rx_byte(8'h3C);
        wait_rsp(5);

        // 6: CMD_VLD held high -> one frame per accept, second accept right after RSP_VLD
        tx_q.push_back(8'hBB); tx_q.push_back(8'h01);
        tx_q.push_back(8'hBB); tx_q.push_back(8'h01);
        rsp_q.push_back(mk(2'd1, 16'h00A5));
        rsp_q.push_back(mk(2'd1, 16'h005B));
        sig.CMD_TYPE = 2'd1; sig.CMD_ADDR = 4'd1; sig.CMD_VLD = 1'b1;
        for (int i = 0; i < 100 && !sig.CMD_RDY; i++) tick();
        tick();
        for (int i = 0; i < 100 && tx_q.size() > 2; i++) tick();
        chk("t6_first_frame", tx_q.size(), 32'd2);
        rx_byte(8'hA5);
        chk("t6_rsp_vld", {31'd0, sig.RSP_VLD}, 32'd1);
        chk("t6_rdy_in_done", {31'd0, sig.CMD_RDY}, 32'd0);
        tick();
        chk("t6_rdy_idle", {31'd0, sig.CMD_RDY}, 32'd1);
        tick();
        chk("t6_busy_again", {31'd0, sig.BUSY}, 32'd1);
        sig.CMD_VLD = 1'b0;
        wait_tx_done();
        rx_byte(8'h5B);
        wait_rsp(7);
        for (int i = 0; i < 5; i++) tick();
        chk("t6_rsp_total", rsp_cnt, 32'd7);
        chk("rsp_q_empty", rsp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got %0d vectors expected completion", n_vec);
        $fatal(1, "watchdog");
    end

endmodule
